// File: rtl/bin2bcd_conv.sv
// Binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle,
// with valid/ready handshakes on both sides and an optional signed (sign-magnitude) mode.
module bin2bcd_conv #(
   parameter int unsigned BIN_W  = 16,
   parameter int unsigned DIGITS = 5,
   parameter int unsigned SIGNED = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [BIN_W-1:0]      i_bin_in,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [4*DIGITS-1:0]   o_bcd_out,
   output logic                  o_sign_out,
   output logic                  o_busy
);

   localparam int unsigned CNT_W      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   // ceil(BIN_W * log10(2)) in integer arithmetic
   localparam int unsigned MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

   if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("bin2bcd_conv: DIGITS too small for BIN_W");
   end

   typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [BIN_W-1:0]      r_mag;
   logic [4*DIGITS-1:0]   r_dig;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_sign_pend;
   logic [4*DIGITS-1:0]   r_bcd;
   logic                  r_sign;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_neg;
   logic [BIN_W-1:0]      w_mag_load;
   logic [4*DIGITS-1:0]   w_corr;
   logic [4*DIGITS-1:0]   w_shift;

   assign w_in_ready = (r_state == StIdle) | ((r_state == StHold) & i_out_ready);
   assign w_accept   = i_in_valid & w_in_ready;
   assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));
   assign w_neg      = (SIGNED != 0) & i_bin_in[BIN_W-1];
   // Negation wraps the minimum value onto 2^(BIN_W-1), which is the correct magnitude.
   assign w_mag_load = w_neg ? (~i_bin_in + BIN_W'(1)) : i_bin_in;

   always_comb begin
      w_corr = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         logic [3:0] d;
         d = r_dig[4*i +: 4];
         w_corr[4*i +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
      end
   end

   assign w_shift = (w_corr << 1) | {{(4*DIGITS-1){1'b0}}, r_mag[BIN_W-1]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StShift;
         StShift: if (w_last) w_state_next = StHold;
         StHold: begin
            if (w_accept) begin
               w_state_next = StShift;
            end else if (i_out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_in_ready  = w_in_ready;
      o_out_valid = (r_state == StHold);
      o_busy      = (r_state == StShift);
      o_bcd_out   = r_bcd;
      o_sign_out  = (SIGNED != 0) ? r_sign : 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mag       <= '0;
         r_dig       <= '0;
         r_cnt       <= '0;
         r_sign_pend <= 1'b0;
         r_bcd       <= '0;
         r_sign      <= 1'b0;
      end else if (w_accept) begin
         r_mag       <= w_mag_load;
         r_dig       <= '0;
         r_cnt       <= '0;
         r_sign_pend <= w_neg;
      end else if (r_state == StShift) begin
         r_mag <= r_mag << 1;
         r_dig <= w_shift;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_bcd  <= w_shift;
            r_sign <= r_sign_pend;
         end
      end
   end

endmodule

// File: doc/bin2bcd_conv.md
Name: bin2bcd_conv

Overview:
- Parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts one BIN_W-bit binary word into DIGITS packed BCD digits.
- Handshake: valid/ready on input and output, with output backpressure.
- Optional signed mode: converts the magnitude and reports the sign separately.
- Used by display/readout paths that need decimal digits from binary counters or measurements.

Parameters:
- BIN_W, 16, width of the binary input (>=2).
- DIGITS, 5, number of BCD digits produced. Elaboration error if DIGITS*4 < BIN_W*0.30103*4 rounded up, i.e. DIGITS < ceil(BIN_W*log10(2)).
- SIGNED, 0, 1 = bin_in is two's complement; magnitude converted, sign on sign_out.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, bin_in valid.
- in_ready, output, 1, converter can accept a word.
- bin_in, input, BIN_W, binary value.
- out_valid, output, 1, bcd_out/sign_out valid.
- out_ready, input, 1, consumer accepts result.
- bcd_out, output, 4*DIGITS, packed BCD, digit 0 (units) in bits [3:0].
- sign_out, output, 1, 1 = negative input (SIGNED=1 only; tied 0 otherwise).
- busy, output, 1, high while in SHIFT state.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, bcd_out=0, sign_out=0, out_valid=0, busy=0, shift counter=0, internal digit register=0. Reset overrides all other inputs, including mid-conversion and mid-output-hold; any in-flight result is discarded.
- States: IDLE, SHIFT, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready), combinational. in_valid is ignored when in_ready=0.
- Accept = in_valid & in_ready at a posedge.
  - Load magnitude shift reg: SIGNED=1 and bin_in[BIN_W-1]=1 -> two's-complement negation as an unsigned BIN_W-bit value, so the minimum value maps to 2^(BIN_W-1) correctly. Otherwise load bin_in.
  - Latch the sign into a pending-sign register.
  - Clear digit register; counter=0; state -> SHIFT.
- SHIFT, each cycle:
  - Every digit >=5 gets +3 (4-bit, no carry between digits).
  - The digit chain is then shifted left 1 bit: each digit's MSB (after correction) enters the next digit's LSB; the magnitude MSB enters digit 0 LSB; the magnitude reg shifts left.
  - Counter increments.
  - On the BIN_W-th shift cycle (counter==BIN_W-1): load bcd_out from the corrected+shifted digits, load sign_out from the pending sign, state -> HOLD.
- Latency: accept at edge t -> out_valid=1 after edge t+BIN_W. Exactly BIN_W SHIFT cycles.
- HOLD: out_valid=1. bcd_out and sign_out stable until out_valid & out_ready.
  - On handshake without a new accept: out_valid -> 0, state -> IDLE.
  - On handshake with a simultaneous accept: go directly to SHIFT (back-to-back). Throughput is 1 word per BIN_W+1 cycles with out_ready held high.
- bcd_out and sign_out retain their last values after out_valid drops (not cleared until the next result or reset).
- Digits above the value's significant digits read 0. Every digit is always in 0..9.
- busy=1 exactly in SHIFT.

Test Plan:
- BIN_W=16, DIGITS=5, SIGNED=0: accept 16'hFFFF with out_ready=1 -> out_valid rises 16 cycles after accept; bcd_out=20'h65535; in_ready=0 throughout SHIFT.
- Same config: 0 -> 20'h00000; 9 -> 20'h00009; 10 -> 20'h00010; 4095 -> 20'h04095. Each result has 16-cycle latency.
- SIGNED=1, BIN_W=16: 16'h8000 -> sign_out=1, bcd_out=20'h32768; 16'hFFFF -> sign_out=1, 20'h00001; 16'h7FFF -> sign_out=0, 20'h32767.
- Backpressure: hold out_ready=0 for 10 cycles after result 1234 -> out_valid stays 1, bcd_out=20'h01234 stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready with in_valid=1 (value 42) in the same cycle -> SHIFT entered next cycle, 20'h00042 appears 16 cycles later.
- Reset mid-conversion: assert rst at shift 7 of 16 -> next cycle state IDLE, out_valid=0, bcd_out=0, in_ready=1. A new conversion of 100 then yields 20'h00100 with normal latency.
- BIN_W=8, DIGITS=3: 255 -> 12'h255, with out_valid 8 cycles after accept. Continuous back-to-back stream of 8 inputs with out_ready=1 -> one result every 9 cycles, all correct.
